// File: rtl/game_timer_pkg.sv
// Shared types and constants for the game timer: FSM state encoding and BCD digit limits.
package game_timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef logic [3:0] digit_t;

    localparam digit_t      BCD_MAX = 4'd9;
    localparam digit_t      BCD_MIN = 4'd0;
    localparam logic [11:0] BCD_TOP = {BCD_MAX, BCD_MAX, BCD_MAX};

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit with load, increment/decrement and ripple carry/borrow to the next digit.
module bcd_digit
    import game_timer_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   inc,
    input  logic   dec,
    input  logic   load,
    input  digit_t ld_val,
    output digit_t value,
    output logic   carry_out,
    output logic   borrow_out
);

    assign carry_out  = inc && (value == BCD_MAX);
    assign borrow_out = dec && (value == BCD_MIN);

    // A non-decimal load value is clamped so the digit never leaves 0..9.
    always_ff @(posedge clk) begin
        if (!reset_n)
            value <= BCD_MIN;
        else if (load)
            value <= (ld_val > BCD_MAX) ? BCD_MAX : ld_val;
        else if (inc)
            value <= carry_out ? BCD_MIN : value + 4'd1;
        else if (dec)
            value <= borrow_out ? BCD_MAX : value - 4'd1;
    end

endmodule

// File: rtl/game_timer_ctrl.sv
// Game round timer: 0.1 s prescaler, 3-digit BCD counter, frame-synchronous display snapshot.
// Define GAME_TIMER_COUNTDOWN_EN to count down from PRESET instead of up from 00.0.
module game_timer_ctrl
    import game_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 10_000_000,
    parameter logic [11:0] PRESET   = 12'h600
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        pause,
    input  logic        clear,
    input  logic        frame_strobe,
    output logic [11:0] disp_digits,
    output logic        second_tick,
    output logic        time_up,
    output logic [1:0]  state
);

    localparam logic [23:0] PRESC_LAST = 24'(TICK_DIV - 1);

    state_t      st;
    logic [23:0] presc;
    logic        run_en, unit_tick, start_run, terminal;
    logic        step_up, step_dn, sec_wrap, ld;
    logic [11:0] live, ld_val;
    logic [2:0]  inc_c, dec_c, carry, borrow;
    digit_t      dig [3];

    assign state     = st;
    assign run_en    = (st == RUN) && !pause && !clear;
    assign unit_tick = run_en && (presc == PRESC_LAST);
    assign start_run = (st == IDLE) && start;
    assign live      = {dig[2], dig[1], dig[0]};

`ifdef GAME_TIMER_COUNTDOWN_EN
    localparam logic [11:0] LOAD_VAL = PRESET;
    // The tick that lands on 00.0 (or finds it already there) ends the run.
    assign terminal = (live[11:4] == 8'h00) && (live[3:0] <= 4'd1);
    assign step_up  = 1'b0;
    assign step_dn  = unit_tick && (live != 12'h000);
    assign sec_wrap = borrow[0];
`else
    // Count-up always starts from zero; PRESET has no effect in this build.
    localparam logic [11:0] LOAD_VAL = PRESET & 12'h000;
    assign terminal = (live == BCD_TOP);
    assign step_up  = unit_tick && !terminal;
    assign step_dn  = 1'b0;
    assign sec_wrap = carry[0];
`endif

    assign ld     = clear || start_run;
    assign ld_val = clear ? 12'h000 : LOAD_VAL;
    assign inc_c  = {carry[1:0], step_up};
    assign dec_c  = {borrow[1:0], step_dn};

    logic unused_chain;
    assign unused_chain = carry[2] | borrow[2];

    for (genvar i = 0; i < 3; i++) begin : g_dig
        bcd_digit u_dig (
            .clk        (clk),
            .reset_n    (reset_n),
            .inc        (inc_c[i]),
            .dec        (dec_c[i]),
            .load       (ld),
            .ld_val     (ld_val[i*4 +: 4]),
            .value      (dig[i]),
            .carry_out  (carry[i]),
            .borrow_out (borrow[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st          <= IDLE;
            presc       <= '0;
            disp_digits <= '0;
            second_tick <= 1'b0;
            time_up     <= 1'b0;
        end else begin
            second_tick <= sec_wrap;

            if (frame_strobe)
                disp_digits <= clear ? 12'h000 : live;

            if (clear || st == IDLE || st == DONE)
                presc <= '0;
            else if (run_en)
                presc <= (presc == PRESC_LAST) ? 24'd0 : presc + 24'd1;

            if (clear) begin
                st      <= IDLE;
                time_up <= 1'b0;
            end else begin
                case (st)
                    IDLE:    if (start) st <= RUN;
                    RUN: begin
                        if (pause) begin
                            st <= PAUSED;
                        end else if (unit_tick && terminal) begin
                            st      <= DONE;
                            time_up <= 1'b1;
                        end
                    end
                    PAUSED:  if (!pause) st <= RUN;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Bench for game_timer_ctrl: two instances (TICK_DIV 4 and 2) driven in lockstep against a decimal reference model.
module tb_game_timer_ctrl;

`ifdef GAME_TIMER_COUNTDOWN_EN
    localparam logic [11:0] PRE      = 12'h010;
    localparam bit          COUNT_DN = 1'b1;
`else
    localparam logic [11:0] PRE      = 12'h600;
    localparam bit          COUNT_DN = 1'b0;
`endif
    localparam int PRE_T = int'(PRE[11:8]) * 100 + int'(PRE[7:4]) * 10 + int'(PRE[3:0]);

    logic        clk = 1'b0;
    logic        reset_n, start, pause, clear, frame_strobe;
    logic [11:0] disp4, disp2;
    logic        sec4, sec2, up4, up2;
    logic [1:0]  st4, st2;

    always #5 clk = ~clk;

    game_timer_ctrl #(.TICK_DIV(4), .PRESET(PRE)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .clear(clear),
        .frame_strobe(frame_strobe), .disp_digits(disp4), .second_tick(sec4),
        .time_up(up4), .state(st4));

    game_timer_ctrl #(.TICK_DIV(2), .PRESET(PRE)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .clear(clear),
        .frame_strobe(frame_strobe), .disp_digits(disp2), .second_tick(sec2),
        .time_up(up2), .state(st2));

    // Reference: time kept as an integer count of tenths, state as 0..3.
    typedef struct packed {
        int st;
        int cnt;
        int live;
        int disp;
        bit sec;
        bit up;
    } mdl_t;

    mdl_t m4, m2;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int to_bcd(input int v);
        return (v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input bit rn, input bit s, input bit p,
                                   input bit c, input bit f, input int div);
        mdl_t n;
        n = m;
        n.sec = 1'b0;
        if (!rn) begin
            n = '0;
            return n;
        end
        if (f) n.disp = c ? 0 : m.live;
        if (c) begin
            n.st = 0; n.cnt = 0; n.live = 0; n.up = 1'b0;
            return n;
        end
        case (m.st)
            0: if (s) begin
                n.st   = 1;
                n.live = COUNT_DN ? PRE_T : 0;
            end
            1: if (p) n.st = 2;
               else if (m.cnt < div - 1) n.cnt = m.cnt + 1;
               else begin
                   n.cnt = 0;
                   if (!COUNT_DN) begin
                       if (m.live == 999) n.st = 3;
                       else begin
                           n.live = m.live + 1;
                           n.sec  = (n.live % 10 == 0);
                       end
                   end else begin
                       if (m.live <= 1) begin
                           n.live = 0;
                           n.st   = 3;
                       end else begin
                           n.live = m.live - 1;
                           n.sec  = (m.live % 10 == 0);
                       end
                   end
               end
            2: if (!p) n.st = 1;
            default: ;
        endcase
        n.up = (n.st == 3);
        return n;
    endfunction

    // One clock: advance both models with the inputs the DUTs see, then compare at negedge.
    task automatic cyc();
        @(posedge clk);
        m4 = mstep(m4, reset_n, start, pause, clear, frame_strobe, 4);
        m2 = mstep(m2, reset_n, start, pause, clear, frame_strobe, 2);
        @(negedge clk);
        chk("state4", int'(st4), m4.st);
        chk("disp4", int'(disp4), to_bcd(m4.disp));
        chk("sec4", int'(sec4), int'(m4.sec));
        chk("tup4", int'(up4), int'(m4.up));
        chk("presc4", int'(dut4.presc), m4.cnt);
        chk("state2", int'(st2), m2.st);
        chk("disp2", int'(disp2), to_bcd(m2.disp));
        chk("sec2", int'(sec2), int'(m2.sec));
        chk("tup2", int'(up2), int'(m2.up));
        chk("presc2", int'(dut2.presc), m2.cnt);
    endtask

    int nsec, p_exp, d_exp;

    initial begin
        reset_n = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0; frame_strobe = 1'b0;
        m4 = '0; m2 = '0;

        repeat (3) cyc();
        chk("rst_state", int'(st4), 0);
        chk("rst_disp", int'(disp4), 0);
        chk("rst_tup", int'(up4), 0);
        chk("rst_sec", int'(sec4), 0);
        reset_n = 1'b1;
        cyc();

        // Start with a strobe every cycle until one second has elapsed on dut4
        start = 1'b1; frame_strobe = 1'b1;
        cyc();
        start = 1'b0;
        nsec = 0;
`ifndef GAME_TIMER_COUNTDOWN_EN
        repeat (41) begin
            cyc();
            nsec += int'(sec4);
        end
        chk("snap_disp", int'(disp4), 'h010);
        chk("snap_sec", nsec, 1);
`else
        repeat (45) cyc();
        chk("dn_state", int'(st4), 3);
        chk("dn_tup", int'(up4), 1);
        chk("dn_disp", int'(disp4), 'h000);
`endif
        frame_strobe = 1'b0;

        // Pause for 100 cycles mid-run
        clear = 1'b1; cyc(); clear = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        repeat (6) cyc();
        p_exp = m4.cnt;
        d_exp = to_bcd(m4.live);
        pause = 1'b1;
        repeat (99) cyc();
        frame_strobe = 1'b1;
        cyc();
        frame_strobe = 1'b0;
        chk("pause_presc", int'(dut4.presc), p_exp);
        chk("pause_digits", int'(disp4), d_exp);
        chk("pause_state", int'(st4), 2);
        pause = 1'b0;
        cyc();
        chk("resume_hold", int'(dut4.presc), p_exp);
        cyc();
        chk("resume_presc", int'(dut4.presc), (p_exp + 1) % 4);

        // Clear, start and pause together while running
        clear = 1'b1; start = 1'b1; pause = 1'b1;
        cyc();
        chk("ccp_state", int'(st4), 0);
        clear = 1'b0; start = 1'b0; pause = 1'b0; frame_strobe = 1'b1;
        cyc();
        frame_strobe = 1'b0;
        chk("ccp_live", int'(disp4), 0);

        // Clear coinciding with a frame strobe blanks the display
        start = 1'b1; cyc(); start = 1'b0;
        repeat (10) cyc();
        clear = 1'b1; frame_strobe = 1'b1;
        cyc();
        clear = 1'b0; frame_strobe = 1'b0;
        chk("clr_fs_disp", int'(disp4), 0);
        chk("clr_fs_disp2", int'(disp2), 0);

`ifndef GAME_TIMER_COUNTDOWN_EN
        // Saturation at 99.9 on the fast instance
        start = 1'b1; cyc(); start = 1'b0;
        repeat (2010) cyc();
        frame_strobe = 1'b1;
        cyc();
        frame_strobe = 1'b0;
        chk("sat_state", int'(st2), 3);
        chk("sat_tup", int'(up2), 1);
        chk("sat_disp", int'(disp2), 'h999);
        clear = 1'b1; cyc(); clear = 1'b0;
`endif

        // Reset for one cycle mid-run
        start = 1'b1; cyc(); start = 1'b0;
        repeat (9) cyc();
        frame_strobe = 1'b1;
        cyc();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1; frame_strobe = 1'b0;
        chk("mrst_state", int'(st4), 0);
        chk("mrst_disp", int'(disp4), 0);
        chk("mrst_sec", int'(sec4), 0);
        chk("mrst_tup", int'(up4), 0);
        chk("mrst_presc", int'(dut4.presc), 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            start        = ($urandom % 8) == 0;
            clear        = ($urandom % 60) == 0;
            frame_strobe = ($urandom % 3) == 0;
            reset_n      = ($urandom % 300) != 0;
            if (($urandom % 12) == 0) pause = ~pause;
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
